// File: rtl/ulpi_phy_emu.sv
// PHY-side ULPI responder standing in for the USB3300: answers register
// accesses, forwards link transmit packets and injects receive traffic.
module ulpi_phy_emu #(
    parameter logic [7:0]  VENDOR_ID = 8'h24,
    parameter int unsigned RX_GAP    = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_dir_o,
    output logic       ulpi_nxt_o,
    input  logic       ulpi_stp_i,
    input  logic [1:0] linestate_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       rx_last_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    output logic       tx_last_o,
    output logic [7:0] func_ctrl_o,
    output logic [7:0] otg_ctrl_o
);

    typedef enum logic [3:0] {
        IDLE, WR_DATA, WR_STP, RD_NXT, RD_TURN, RD_DATA, RD_BACK, TX,
        RX_TURN, RX_BYTES, RX_END, CMD_TURN, CMD_OUT, BACK
    } state_t;

    localparam logic [7:0] GAP = 8'(RX_GAP);

    state_t     state_q, state_d;
    logic [5:0] addr_q;
    logic [7:0] wr_byte_q;
    logic [7:0] tx_hold_q;
    logic [1:0] ls_rep_q;
    logic [7:0] gap_cnt_q;
    logic       rx_last_seen_q;

    logic       ls_changed;
    logic       rx_accept;
    logic [7:0] rd_value;
    logic       dir_d, nxt_d, rx_ready_d, tx_valid_d, tx_last_d;
    logic [7:0] data_d, tx_data_d;

    assign ls_changed = (linestate_i != ls_rep_q);
    assign rx_accept  = rx_valid_i && (gap_cnt_q >= GAP) &&
                        ((state_q == RX_TURN) || ((state_q == RX_BYTES) && !rx_last_seen_q));

    always_comb begin
        rd_value = 8'h00;
        case (addr_q)
            6'h00:               rd_value = VENDOR_ID;
            6'h04, 6'h05, 6'h06: rd_value = func_ctrl_o;
            6'h0A, 6'h0B, 6'h0C: rd_value = otg_ctrl_o;
            default:             rd_value = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Receive injection wins over a pending linestate report, which wins over the link's TX CMD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    state_d = RX_TURN;
                end else if (ls_changed) begin
                    state_d = CMD_TURN;
                end else begin
                    case (ulpi_data_i[7:6])
                        2'b01:   state_d = TX;
                        2'b10:   state_d = WR_DATA;
                        2'b11:   state_d = RD_NXT;
                        default: state_d = IDLE;
                    endcase
                end
            end
            WR_DATA:  state_d = WR_STP;
            WR_STP:   state_d = IDLE;
            RD_NXT:   state_d = RD_TURN;
            RD_TURN:  state_d = RD_DATA;
            RD_DATA:  state_d = RD_BACK;
            RD_BACK:  state_d = IDLE;
            TX:       state_d = ulpi_stp_i ? IDLE : TX;
            RX_TURN:  state_d = RX_BYTES;
            RX_BYTES: state_d = rx_last_seen_q ? RX_END : RX_BYTES;
            RX_END:   state_d = BACK;
            CMD_TURN: state_d = CMD_OUT;
            CMD_OUT:  state_d = BACK;
            BACK:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are registered, so their next values are decoded from the state being entered.
    always_comb begin
        dir_d      = 1'b0;
        nxt_d      = 1'b0;
        data_d     = 8'h00;
        rx_ready_d = 1'b0;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        tx_data_d  = 8'h00;
        case (state_d)
            WR_DATA, RD_NXT, TX: nxt_d = 1'b1;
            RD_TURN, CMD_TURN:   dir_d = 1'b1;
            RD_DATA: begin
                dir_d  = 1'b1;
                data_d = rd_value;
            end
            RX_TURN: begin
                dir_d = 1'b1;
                nxt_d = 1'b1;
            end
            RX_BYTES: begin
                dir_d = 1'b1;
                if (rx_accept) begin
                    nxt_d      = 1'b1;
                    data_d     = rx_data_i;
                    rx_ready_d = 1'b1;
                end else begin
                    data_d = {2'b00, 2'b01, 2'b11, linestate_i};
                end
            end
            RX_END, CMD_OUT: begin
                dir_d  = 1'b1;
                data_d = {2'b00, 2'b00, 2'b11, linestate_i};
            end
            default: ;
        endcase
        if (state_q == TX) begin
            tx_valid_d = 1'b1;
            tx_data_d  = tx_hold_q;
            tx_last_d  = ulpi_stp_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ulpi_dir_o     <= 1'b0;
            ulpi_nxt_o     <= 1'b0;
            ulpi_data_o    <= 8'h00;
            rx_ready_o     <= 1'b0;
            tx_valid_o     <= 1'b0;
            tx_last_o      <= 1'b0;
            tx_data_o      <= 8'h00;
            func_ctrl_o    <= 8'h41;
            otg_ctrl_o     <= 8'h06;
            addr_q         <= 6'h00;
            wr_byte_q      <= 8'h00;
            tx_hold_q      <= 8'h00;
            ls_rep_q       <= linestate_i;
            gap_cnt_q      <= 8'h00;
            rx_last_seen_q <= 1'b0;
        end else begin
            ulpi_dir_o  <= dir_d;
            ulpi_nxt_o  <= nxt_d;
            ulpi_data_o <= data_d;
            rx_ready_o  <= rx_ready_d;
            tx_valid_o  <= tx_valid_d;
            tx_last_o   <= tx_last_d;
            tx_data_o   <= tx_data_d;

            if (state_q == IDLE) begin
                addr_q <= ulpi_data_i[5:0];
            end
            if ((state_q == IDLE) || (state_q == TX)) begin
                tx_hold_q <= ulpi_data_i;
            end
            if (state_q == WR_DATA) begin
                wr_byte_q <= ulpi_data_i;
            end

            if ((state_q == WR_STP) && ulpi_stp_i) begin
                case (addr_q)
                    6'h04:   func_ctrl_o <= wr_byte_q;
                    6'h05:   func_ctrl_o <= func_ctrl_o | wr_byte_q;
                    6'h06:   func_ctrl_o <= func_ctrl_o & ~wr_byte_q;
                    6'h0A:   otg_ctrl_o  <= wr_byte_q;
                    6'h0B:   otg_ctrl_o  <= otg_ctrl_o | wr_byte_q;
                    6'h0C:   otg_ctrl_o  <= otg_ctrl_o & ~wr_byte_q;
                    default: ;
                endcase
            end

            if (state_d == CMD_OUT) begin
                ls_rep_q <= linestate_i;
            end

            // The gap counter starts saturated so the first byte can follow the turnaround directly.
            if (state_d == RX_TURN) begin
                gap_cnt_q      <= GAP;
                rx_last_seen_q <= 1'b0;
            end else if (rx_accept) begin
                gap_cnt_q      <= 8'h00;
                rx_last_seen_q <= rx_last_i;
            end else if ((state_q == RX_BYTES) && (gap_cnt_q != 8'hFF)) begin
                gap_cnt_q <= gap_cnt_q + 8'h01;
            end
        end
    end

endmodule
